// File: rtl/fmap_pkg.sv
// Shared types and helpers for the feature-map buffer: default geometry,
// write-side FSM state encoding and the lane-count clamp.
package fmap_pkg;

  localparam int DATA_WIDTH_DEFAULT = 16;
  localparam int LANES_DEFAULT      = 16;

  typedef enum logic {
    IDLE,
    ROW1
  } wr_state_t;

  // Write beats may claim more lanes than physically exist; cap at LANES.
  function automatic int clamp_count(input int count, input int lanes);
    return (count > lanes) ? lanes : count;
  endfunction

endpackage

// File: rtl/fmap_wr_fsm.sv
// Write-side handshake and upsample sequencer: turns each accepted beat into
// one (normal) or two (upsample) cycles of lane enables for the memory array.
module fmap_wr_fsm
  import fmap_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int LANES      = LANES_DEFAULT,
  parameter int ADDR_WIDTH = 19,
  parameter int OFM_WIDTH  = 9,
  parameter int CW         = $clog2(LANES) + 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_valid_i,
  output logic                        wr_ready_o,
  input  logic [ADDR_WIDTH-1:0]       wr_addr_i,
  input  logic [LANES*DATA_WIDTH-1:0] wr_data_i,
  input  logic [CW-1:0]               wr_count_i,
  input  logic                        upsample_mode_i,
  input  logic [OFM_WIDTH-1:0]        ofm_size_i,
  output logic                        wr_busy_o,
  output logic [LANES-1:0]            lane_en_o,
  output logic [ADDR_WIDTH-1:0]       base_addr_o,
  output logic                        dup_o,
  output logic [LANES*DATA_WIDTH-1:0] lane_data_o
);

  wr_state_t                   state_q;
  logic                        wr_ready_q;
  logic                        wr_busy_q;
  logic [ADDR_WIDTH-1:0]       hold_addr_q;
  logic [LANES*DATA_WIDTH-1:0] hold_data_q;
  logic [CW-1:0]               hold_count_q;
  logic [OFM_WIDTH-1:0]        hold_ofm_q;

  logic          handshake;
  logic [CW-1:0] count_clamped;

  assign handshake     = wr_valid_i && wr_ready_q;
  assign count_clamped = CW'(clamp_count(32'(wr_count_i), LANES));
  assign wr_ready_o    = wr_ready_q;
  assign wr_busy_o     = wr_busy_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wr_ready_q   <= 1'b1;
      wr_busy_q    <= 1'b0;
      hold_addr_q  <= '0;
      hold_data_q  <= '0;
      hold_count_q <= '0;
      hold_ofm_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (handshake && upsample_mode_i) begin
            state_q      <= ROW1;
            wr_ready_q   <= 1'b0;
            wr_busy_q    <= 1'b1;
            hold_addr_q  <= wr_addr_i;
            hold_data_q  <= wr_data_i;
            hold_count_q <= count_clamped;
            hold_ofm_q   <= ofm_size_i;
          end
        end
        ROW1: begin
          state_q    <= IDLE;
          wr_ready_q <= 1'b1;
          wr_busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: every output gets a default before any branch so no latch is inferred.
  always_comb begin
    lane_en_o   = '0;
    base_addr_o = '0;
    dup_o       = 1'b0;
    lane_data_o = '0;
    if (state_q == ROW1) begin
      // Second upsample row sits one output row pitch below the first.
      base_addr_o = hold_addr_q + ADDR_WIDTH'(hold_ofm_q);
      dup_o       = 1'b1;
      lane_data_o = hold_data_q;
      for (int i = 0; i < LANES; i++) lane_en_o[i] = (CW'(i) < hold_count_q);
    end else if (handshake) begin
      base_addr_o = wr_addr_i;
      dup_o       = upsample_mode_i;
      lane_data_o = wr_data_i;
      for (int i = 0; i < LANES; i++) lane_en_o[i] = (CW'(i) < count_clamped);
    end
  end

endmodule

// File: rtl/fmap_buffer.sv
// Dual-port feature-map buffer: LANES-wide read-first reads, up to LANES-word
// writes per beat, optional 2x nearest-neighbour upsample on the write side.
module fmap_buffer
  import fmap_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int LANES      = LANES_DEFAULT,
  parameter int DEPTH      = 524288,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int OFM_WIDTH  = 9
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rd_en,
  input  logic [ADDR_WIDTH-1:0]       rd_addr,
  output logic [LANES*DATA_WIDTH-1:0] rd_data,
  output logic                        rd_valid,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [ADDR_WIDTH-1:0]       wr_addr,
  input  logic [LANES*DATA_WIDTH-1:0] wr_data,
  input  logic [$clog2(LANES):0]      wr_count,
  input  logic                        upsample_mode,
  input  logic [OFM_WIDTH-1:0]        ofm_size,
  output logic                        wr_busy
);

  logic [DATA_WIDTH-1:0]       mem [DEPTH];
  logic [LANES*DATA_WIDTH-1:0] rd_data_q;
  logic                        rd_valid_q;

  logic [LANES-1:0]            lane_en;
  logic [ADDR_WIDTH-1:0]       base_addr;
  logic                        dup;
  logic [LANES*DATA_WIDTH-1:0] lane_data;

  fmap_wr_fsm #(
    .DATA_WIDTH (DATA_WIDTH),
    .LANES      (LANES),
    .ADDR_WIDTH (ADDR_WIDTH),
    .OFM_WIDTH  (OFM_WIDTH),
    .CW         ($clog2(LANES) + 1)
  ) u_wr_fsm (
    .clk             (clk),
    .rst_n           (rst_n),
    .wr_valid_i      (wr_valid),
    .wr_ready_o      (wr_ready),
    .wr_addr_i       (wr_addr),
    .wr_data_i       (wr_data),
    .wr_count_i      (wr_count),
    .upsample_mode_i (upsample_mode),
    .ofm_size_i      (ofm_size),
    .wr_busy_o       (wr_busy),
    .lane_en_o       (lane_en),
    .base_addr_o     (base_addr),
    .dup_o           (dup),
    .lane_data_o     (lane_data)
  );

  // NOTE: the array has no reset; clearing DEPTH words is neither needed nor
  // mappable onto block RAM, so contents are undefined until written.
  always_ff @(posedge clk) begin
    // Ascending lane order lets the higher lane win on overlapping addresses.
    for (int i = 0; i < LANES; i++) begin
      if (lane_en[i]) begin
        if (dup) begin
          mem[base_addr + ADDR_WIDTH'(2*i)]     <= lane_data[i*DATA_WIDTH +: DATA_WIDTH];
          mem[base_addr + ADDR_WIDTH'(2*i + 1)] <= lane_data[i*DATA_WIDTH +: DATA_WIDTH];
        end else begin
          mem[base_addr + ADDR_WIDTH'(i)]       <= lane_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Reads sample the array before this edge's writes land (read-first).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else if (rd_en) begin
      for (int i = 0; i < LANES; i++)
        rd_data_q[i*DATA_WIDTH +: DATA_WIDTH] <= mem[rd_addr + ADDR_WIDTH'(i)];
      rd_valid_q <= 1'b1;
    end else begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_fmap_buffer.sv
// Directed bench for fmap_buffer: read expectations go into a scoreboard queue
// and a negedge monitor compares them whenever rd_valid is presented.
module tb_fmap_buffer;

  localparam int DW    = 16;
  localparam int LN    = 16;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int OW    = 9;
  localparam int CW    = 5;
  localparam int BW    = LN * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [BW-1:0] rd_data;
  logic          rd_valid;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [AW-1:0] wr_addr = '0;
  logic [BW-1:0] wr_data = '0;
  logic [CW-1:0] wr_count = '0;
  logic          upsample_mode = 1'b0;
  logic [OW-1:0] ofm_size = '0;
  logic          wr_busy;

  fmap_buffer #(
    .DATA_WIDTH (DW),
    .LANES      (LN),
    .DEPTH      (DEPTH),
    .OFM_WIDTH  (OW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_count      (wr_count),
    .upsample_mode (upsample_mode),
    .ofm_size      (ofm_size),
    .wr_busy       (wr_busy)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [BW-1:0] data;
    logic [BW-1:0] mask;
    int            tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every presented read must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && rd_valid) begin
      if (sb.size() == 0) begin
        check("rd_unexpected", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.mask != '0)
          check($sformatf("rd_tag%0d", mon_e.tag), rd_data & mon_e.mask, mon_e.data & mon_e.mask);
      end
    end
  end

  function automatic logic [BW-1:0] rep(input logic [DW-1:0] x);
    logic [BW-1:0] r;
    for (int i = 0; i < LN; i++) r[i*DW +: DW] = x;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [BW-1:0] d, input logic [BW-1:0] m, input int tag);
    exp_t e;
    e.data = d;
    e.mask = m;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic rd_read(input logic [AW-1:0] addr, input logic [BW-1:0] d,
                         input logic [BW-1:0] m, input int tag);
    push_exp(d, m, tag);
    rd_en   = 1'b1;
    rd_addr = addr;
    step();
    rd_en   = 1'b0;
  endtask

  // Offer one beat and hold it until the DUT accepts it (bounded).
  task automatic wr_beat(input logic [AW-1:0] addr, input logic [BW-1:0] data,
                         input logic [CW-1:0] cnt, input logic up, input logic [OW-1:0] ofm);
    bit accepted = 1'b0;
    wr_valid      = 1'b1;
    wr_addr       = addr;
    wr_data       = data;
    wr_count      = cnt;
    upsample_mode = up;
    ofm_size      = ofm;
    for (int k = 0; k < 20 && !accepted; k++) begin
      @(negedge clk);
      accepted = wr_ready;
      step();
    end
    wr_valid = 1'b0;
    if (!accepted) check("wr_accept_timeout", 0, 1);
    else acc_cyc = cyc;
  endtask

  logic [BW-1:0] v, e, m;
  int first_acc, prev_acc;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rd_data", rd_data, 0);
    check("reset_rd_valid", BW'(rd_valid), 0);
    check("reset_wr_ready", BW'(wr_ready), 1);
    check("reset_wr_busy", BW'(wr_busy), 0);
    step();
    rst_n = 1'b1;
    step();

    // Read of unwritten memory: only the valid strobe and idle zeroing matter.
    rd_read(0, '0, '0, 0);
    @(negedge clk);
    check("rd_valid_after_read", BW'(rd_valid), 1);
    step();
    @(negedge clk);
    check("rd_valid_idle", BW'(rd_valid), 0);
    check("rd_data_idle", rd_data, 0);
    step();

    // Partial normal write over a 0xFFFF background.
    wr_beat(96, rep(16'hFFFF), 16, 1'b0, 0);
    wr_beat(112, rep(16'hFFFF), 16, 1'b0, 0);
    for (int i = 0; i < LN; i++) v[i*DW +: DW] = DW'(i + 1);
    wr_beat(100, v, 5, 1'b0, 0);
    e = rep(16'hFFFF);
    for (int i = 0; i < 5; i++) e[i*DW +: DW] = DW'(i + 1);
    rd_read(100, e, '1, 1);
    wr_beat(100, rep(16'hEEEE), 0, 1'b0, 0);
    rd_read(100, e, '1, 2);

    // Single upsample beat: rows at 0 and 32.
    wr_beat(0, rep(16'h0000), 16, 1'b0, 0);
    wr_beat(32, rep(16'h0000), 16, 1'b0, 0);
    v = '0;
    v[15:0]  = 16'd7;
    v[31:16] = 16'd9;
    wr_beat(0, v, 2, 1'b1, 32);
    @(negedge clk);
    check("ups_ready_low", BW'(wr_ready), 0);
    check("ups_busy_high", BW'(wr_busy), 1);
    step();
    @(negedge clk);
    check("ups_ready_back", BW'(wr_ready), 1);
    check("ups_busy_back", BW'(wr_busy), 0);
    step();
    e = '0;
    e[15:0]  = 16'd7;
    e[31:16] = 16'd7;
    e[47:32] = 16'd9;
    e[63:48] = 16'd9;
    rd_read(0, e, '1, 3);
    rd_read(32, e, '1, 4);

    // Four back-to-back upsample beats with wr_valid held high throughout.
    for (int b = 0; b < 4; b++) begin
      v = '0;
      v[15:0] = 16'hA0 + DW'(b);
      wr_beat(AW'(320 + 2*b), v, 1, 1'b1, 16);
      if (b == 0) first_acc = acc_cyc;
      else check($sformatf("b2b_gap%0d", b), BW'(acc_cyc - prev_acc), 2);
      prev_acc = acc_cyc;
    end
    @(negedge clk);
    check("b2b_last_busy", BW'(wr_busy), 1);
    step();
    @(negedge clk);
    check("b2b_busy_done", BW'(wr_busy), 0);
    check("b2b_cycles", BW'(cyc - first_acc + 1), 8);
    step();
    e = '0;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      e[i*DW +: DW] = 16'hA0 + DW'(i / 2);
      m[i*DW +: DW] = '1;
    end
    rd_read(320, e, m, 5);
    rd_read(336, e, m, 6);

    // Same-edge read and write: old data first, new data on the next read.
    v = '0;
    v[15:0] = 16'h1111;
    wr_beat(200, v, 1, 1'b0, 0);
    e = '0;
    e[15:0] = 16'h1111;
    m = '0;
    m[15:0] = 16'hFFFF;
    push_exp(e, m, 7);
    rd_en   = 1'b1;
    rd_addr = 200;
    v[15:0] = 16'h2222;
    wr_beat(200, v, 1, 1'b0, 0);
    rd_en   = 1'b0;
    e[15:0] = 16'h2222;
    rd_read(200, e, m, 8);

    // Address wrap: DEPTH-2, DEPTH-1, 0, 1.
    v = '0;
    for (int i = 0; i < 4; i++) v[i*DW +: DW] = 16'h51 + DW'(i);
    wr_beat(AW'(DEPTH - 2), v, 4, 1'b0, 0);
    e = '0;
    for (int i = 0; i < 4; i++) e[i*DW +: DW] = 16'h51 + DW'(i);
    e[79:64] = 16'd9;
    e[95:80] = 16'd9;
    rd_read(AW'(DEPTH - 2), e, '1, 9);

    // Oversized count clamps to all 16 lanes and nothing beyond.
    wr_beat(400, rep(16'hFFFF), 16, 1'b0, 0);
    wr_beat(416, rep(16'hFFFF), 16, 1'b0, 0);
    for (int i = 0; i < LN; i++) v[i*DW +: DW] = 16'hC00 + DW'(i);
    wr_beat(400, v, 20, 1'b0, 0);
    rd_read(400, v, '1, 10);
    rd_read(416, rep(16'hFFFF), '1, 11);

    // Reset during ROW1 keeps row 0 and drops row 1.
    wr_beat(500, rep(16'hFFFF), 16, 1'b0, 0);
    wr_beat(516, rep(16'hFFFF), 16, 1'b0, 0);
    v = '0;
    v[15:0] = 16'h77;
    wr_beat(500, v, 1, 1'b1, 16);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_reset_busy", BW'(wr_busy), 0);
    check("mid_reset_ready", BW'(wr_ready), 1);
    step();
    rst_n = 1'b1;
    step();
    e = rep(16'hFFFF);
    e[15:0]  = 16'h77;
    e[31:16] = 16'h77;
    rd_read(500, e, '1, 12);
    rd_read(516, rep(16'hFFFF), '1, 13);

    repeat (3) step();
    check("sb_drained", BW'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
